// File: rtl/medidor_pkg.sv
// Shared definitions for the HC-SR04 distance meter.
// Holds the FSM state encoding (also exported on db_estado), the BCD digit
// width, the saturation value of the 3-digit centimetre counter and a
// helper that adds one to a 3-digit packed BCD number.
package medidor_pkg;

  localparam int          DIGITO_W     = 4;
  localparam logic [11:0] BCD_SATURADO = 12'h999;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    TRIGGER     = 4'd2,
    ESPERA_ECHO = 4'd3,
    MEDE        = 4'd4,
    ARMAZENA    = 4'd5,
    FINAL       = 4'd6
  } estado_t;

  // Adds one with decimal carry between digits. The caller must keep the
  // value below 999 because the hundreds digit is not checked here.
  function automatic logic [3*DIGITO_W-1:0] bcd_incrementa(input logic [3*DIGITO_W-1:0] v);
    logic [DIGITO_W-1:0] unidade;
    logic [DIGITO_W-1:0] dezena;
    logic [DIGITO_W-1:0] centena;
    unidade = v[DIGITO_W-1:0];
    dezena  = v[2*DIGITO_W-1:DIGITO_W];
    centena = v[3*DIGITO_W-1:2*DIGITO_W];
    if (unidade == DIGITO_W'(9)) begin
      unidade = '0;
      if (dezena == DIGITO_W'(9)) begin
        dezena  = '0;
        centena = centena + DIGITO_W'(1);
      end else begin
        dezena = dezena + DIGITO_W'(1);
      end
    end else begin
      unidade = unidade + DIGITO_W'(1);
    end
    return {centena, dezena, unidade};
  endfunction

endpackage

// File: rtl/medidor_distancia_hcsr04_if.sv
// Signal bundle between the turret controller / sensor pins and the
// distance meter.
//   medir        start request (controller -> meter)
//   echo         raw sensor echo (sensor -> meter)
//   trigger      sensor trigger pulse (meter -> sensor)
//   medida       distance in cm, BCD {centena,dezena,unidade}
//   pronto       one-cycle completion pulse
//   erro_timeout measurement timed out (valid with pronto)
//   db_estado    current FSM state code
// master: the side driving medir/echo; slave: the meter itself.
interface medidor_distancia_hcsr04_if;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        erro_timeout;
  logic [3:0]  db_estado;

  modport master (
    output medir, echo,
    input  trigger, medida, pronto, erro_timeout, db_estado
  );

  modport slave (
    input  medir, echo,
    output trigger, medida, pronto, erro_timeout, db_estado
  );
endinterface

// File: rtl/contador_cm_bcd.sv
// Converts echo-high clock cycles into rounded centimetres.
// A tick divider, preloaded with half a centimetre's worth of clocks, wraps
// every CICLOS_POR_CM enabled clocks; each wrap adds one to a 3-digit BCD
// counter that saturates at 999.  Result = floor((n + C/2) / C).
// Ports: clock, reset (async active-low), clear (zero the BCD counter),
// preload (load divider with C/2), enable (count this clock), valor (BCD).
module contador_cm_bcd
  import medidor_pkg::*;
#(
  parameter int CICLOS_POR_CM = 2941
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        preload,
  input  logic        enable,
  output logic [11:0] valor
);

  localparam int                DIV_W    = $clog2(CICLOS_POR_CM);
  localparam logic [DIV_W-1:0]  DIV_MEIO = DIV_W'(CICLOS_POR_CM / 2);
  localparam logic [DIV_W-1:0]  DIV_TOPO = DIV_W'(CICLOS_POR_CM - 1);

  logic [DIV_W-1:0] divisor;
  logic             tick;

  assign tick = enable && (divisor == DIV_TOPO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      divisor <= '0;
    end else if (preload) begin
      divisor <= DIV_MEIO;
    end else if (enable) begin
      divisor <= tick ? '0 : divisor + DIV_W'(1);
    end
  end

  // Saturating counter: once at 999 further ticks are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor <= '0;
    end else if (clear) begin
      valor <= '0;
    end else if (tick && (valor != BCD_SATURADO)) begin
      valor <= bcd_incrementa(valor);
    end
  end

endmodule

// File: rtl/medidor_distancia_hcsr04.sv
// HC-SR04 ultrasonic distance meter.
// On medir: pulse trigger for TRIGGER_CICLOS clocks, wait for a rising edge
// of the synchronized echo, time its high phase, convert to rounded cm in
// BCD and pulse pronto.
// Ports: clock, reset (async active-low), bus (medidor_distancia_hcsr04_if
// slave: medir, echo in; trigger, medida, pronto, erro_timeout, db_estado out).
// Optional macro HCSR04_TIMEOUT_EN adds a TIMEOUT_CICLOS watchdog on the echo
// wait and the echo high time; without it erro_timeout is tied low.
module medidor_distancia_hcsr04
  import medidor_pkg::*;
#(
  parameter int TRIGGER_CICLOS = 500,
  parameter int CICLOS_POR_CM  = 2941
`ifdef HCSR04_TIMEOUT_EN
  , parameter int TIMEOUT_CICLOS = 1_500_000
`endif
) (
  input logic                        clock,
  input logic                        reset,
  medidor_distancia_hcsr04_if.slave  bus
);

  localparam int                TRIG_W      = $clog2(TRIGGER_CICLOS + 1);
  localparam logic [TRIG_W-1:0] TRIG_ULTIMO = TRIG_W'(TRIGGER_CICLOS - 1);

  estado_t           estado;
  logic [TRIG_W-1:0] trig_cnt;
  logic              echo_meta;
  logic              echo_sinc;
  logic              echo_ant;
  logic              echo_subida;
  logic              trigger_q;
  logic              pronto_q;
  logic [11:0]       medida_q;
  logic [11:0]       valor_bcd;
  logic              wd_estouro;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_meta <= 1'b0;
      echo_sinc <= 1'b0;
      echo_ant  <= 1'b0;
    end else begin
      echo_meta <= bus.echo;
      echo_sinc <= echo_meta;
      echo_ant  <= echo_sinc;
    end
  end

  assign echo_subida = echo_sinc && !echo_ant;

`ifdef HCSR04_TIMEOUT_EN
  localparam int              WD_W      = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [WD_W-1:0] WD_ULTIMO = WD_W'(TIMEOUT_CICLOS - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            erro_q;

  // Watchdog restarts from zero on entry to ESPERA_ECHO (it idles at zero
  // beforehand) and again on the echo edge that enters MEDE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if ((estado == ESPERA_ECHO && !echo_subida) || estado == MEDE) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_estouro       = (wd_cnt == WD_ULTIMO);
  assign bus.erro_timeout = erro_q;
`else
  assign wd_estouro       = 1'b0;
  assign bus.erro_timeout = 1'b0;
`endif

  // Measurement sequencer; trigger, pronto and medida are registered here
  // so each output is asserted exactly for the cycles spent in its state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      trig_cnt  <= '0;
      trigger_q <= 1'b0;
      pronto_q  <= 1'b0;
      medida_q  <= '0;
`ifdef HCSR04_TIMEOUT_EN
      erro_q    <= 1'b0;
`endif
    end else begin
      pronto_q <= 1'b0;
      case (estado)
        INICIAL: begin
          if (bus.medir) estado <= PREPARA;
        end
        PREPARA: begin
          trig_cnt  <= '0;
          trigger_q <= 1'b1;
          estado    <= TRIGGER;
`ifdef HCSR04_TIMEOUT_EN
          erro_q    <= 1'b0;
`endif
        end
        TRIGGER: begin
          if (trig_cnt == TRIG_ULTIMO) begin
            trigger_q <= 1'b0;
            estado    <= ESPERA_ECHO;
          end else begin
            trig_cnt <= trig_cnt + TRIG_W'(1);
          end
        end
        ESPERA_ECHO: begin
          if (echo_subida) begin
            estado <= MEDE;
          end else if (wd_estouro) begin
            estado   <= FINAL;
            pronto_q <= 1'b1;
`ifdef HCSR04_TIMEOUT_EN
            erro_q   <= 1'b1;
`endif
          end
        end
        MEDE: begin
          if (!echo_sinc) begin
            estado <= ARMAZENA;
          end else if (wd_estouro) begin
            estado   <= FINAL;
            pronto_q <= 1'b1;
`ifdef HCSR04_TIMEOUT_EN
            erro_q   <= 1'b1;
`endif
          end
        end
        ARMAZENA: begin
          medida_q <= valor_bcd;
          pronto_q <= 1'b1;
          estado   <= FINAL;
        end
        FINAL: begin
          estado <= INICIAL;
        end
        default: begin
          estado <= INICIAL;
        end
      endcase
    end
  end

  contador_cm_bcd #(
    .CICLOS_POR_CM(CICLOS_POR_CM)
  ) u_contador (
    .clock  (clock),
    .reset  (reset),
    .clear  (estado == PREPARA),
    .preload(estado == PREPARA),
    .enable (estado == MEDE),
    .valor  (valor_bcd)
  );

  assign bus.trigger   = trigger_q;
  assign bus.pronto    = pronto_q;
  assign bus.medida    = medida_q;
  assign bus.db_estado = estado;

endmodule

// File: doc/medidor_distancia_hcsr04.md
Name: medidor_distancia_hcsr04

Overview:
Ultrasonic front-end that sits directly upstream of the turret control unit. On each `medir` request it:
- emits a 10 us trigger pulse to the HC-SR04;
- times the returned echo pulse;
- converts the echo width to centimetres as 3-digit BCD;
- flags completion.

The turret FSM consumes `medida`/`pronto` for threat detection and the serial report.

Parameters:
TRIGGER_CICLOS, 500, trigger high time in clocks (10 us at 50 MHz)
CICLOS_POR_CM, 2941, clocks per cm of echo width (58.82 us/cm)
TIMEOUT_CICLOS, 1_500_000, max wait for echo rise and max echo high time (30 ms); used only with HCSR04_TIMEOUT_EN

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low; one clock; all flops clear on assertion
medir  in  1  start request; sampled on rising clock; ignored unless in INICIAL
echo  in  1  raw sensor echo, asynchronous
trigger  out  1  sensor trigger pulse
medida  out  12  distance in cm, BCD {centena,dezena,unidade}
pronto  out  1  one-cycle pulse when the measurement (or timeout) completes
erro_timeout  out  1  high with pronto when the measurement timed out; held until next medir
db_estado  out  4  current FSM state code

Behaviour:
- Reset values: trigger=0, medida=12'h000, pronto=0, erro_timeout=0, state=INICIAL, all counters 0. Reset mid-operation drops trigger the same instant (asynchronously) and abandons the measurement.
- Echo path: two-flop synchronizer. All edge detection and counting use the synchronized echo, so latency from the raw echo edge is 2 clocks.
- FSM states (db_estado code):
  - INICIAL(0): idle. medir=1 -> PREPARA.
  - PREPARA(1): clear the cm counter and load the tick divider with CICLOS_POR_CM/2 (rounding). Clear erro_timeout. -> TRIGGER next cycle.
  - TRIGGER(2): trigger=1 for exactly TRIGGER_CICLOS clocks -> ESPERA_ECHO.
  - ESPERA_ECHO(3): wait for a synchronized echo rising edge -> MEDE. An echo already high on entry is not counted; a low-to-high transition is required.
  - MEDE(4): the divider counts every clock. Each wrap at CICLOS_POR_CM increments the BCD counter by 1 with decimal carry. Synchronized echo falls -> ARMAZENA.
  - ARMAZENA(5): copy the BCD counter into medida. -> FINAL.
  - FINAL(6): pronto=1 for exactly one cycle -> INICIAL.
- Rounding: cm = floor((clocks_high + CICLOS_POR_CM/2) / CICLOS_POR_CM).
- Saturation: the BCD counter stops at 999 and never wraps to 000.
- medida changes only in ARMAZENA and holds otherwise, including across timeouts.
- Minimum latency from medir to pronto: 1 + TRIGGER_CICLOS + echo wait + echo width + 2 sync + 2 clocks.
- medir held high continuously: a new measurement starts the cycle after FINAL returns to INICIAL.

Optional Feature:
HCSR04_TIMEOUT_EN.
- Defined: a watchdog counter runs in ESPERA_ECHO and MEDE and is reset on entering each state. On reaching TIMEOUT_CICLOS the FSM goes to FINAL with erro_timeout=1 and pronto pulsed; medida keeps its old value.
- Undefined: no watchdog; the FSM waits indefinitely and erro_timeout is tied 0.

Decomposition:
- Package medidor_pkg holds:
  - the state enum/encodings (4-bit codes above);
  - BCD digit width (4);
  - saturation constant 12'h999.
- One sub-module, contador_cm_bcd:
  - inputs: clear, preload, enable;
  - contains the rounding tick divider and the saturating 3-digit BCD counter;
  - output: 12-bit BCD value.

Test Plan:
- Reset asserted low mid-TRIGGER -> trigger=0 immediately; after release, db_estado=0 and medida=000.
- medir pulse; echo starts 400 us after trigger falls, width 5882 us -> trigger high for exactly 500 clocks; medida=12'h100; pronto one cycle; erro_timeout=0.
- Echo widths in sequence -> medida 12'h075, 12'h035, 12'h021 (checks rounding):

  | Echo width | Expected medida |
  |---|---|
  | 4430 us | 12'h075 |
  | 2058 us | 12'h035 |
  | 1235 us | 12'h021 |
- Echo width 65 ms -> medida=12'h999 saturated, no wrap (run with HCSR04_TIMEOUT_EN undefined).
- HCSR04_TIMEOUT_EN defined, echo never rises -> pronto plus erro_timeout exactly 30 ms after trigger falls; medida keeps its previous value.
- medir pulsed while in MEDE, and echo high before the trigger -> the medir is ignored; measurement starts only at the first echo rising edge after TRIGGER.
